aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Round sequencer for the AES cipher datapath inside aes_cipher_top.
//  - Accepts a block via a valid/ready load handshake and strobes the text_in_r/key capture enables.
//  - Steps the round datapath and key expansion through the initial AddRoundKey, NR-1 full rounds
//    and a final round (no MixColumns).
//  - Holds the result with a valid/ready output handshake.
//  - Owns no data, only control.
// PARAMETERS
//  NR     10                 number of cipher rounds (10/12/14 for AES-128/192/256)
//  CNT_W  $clog2(NR+1)       round counter width
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  ld_valid    in   1      new plaintext/key block present on text_in/key
//  ld_ready    out  1      controller can accept a block this cycle
//  out_ready   in   1      consumer accepts text_out
//  out_valid   out  1      text_out holds a finished ciphertext
//  abort       in   1      synchronous cancel of the current block
//  ld_en       out  1      capture enable for text_in_r (and the key register)
//  kexp_ld     out  1      load the key-expansion engine with the round-0 key
//  kexp_en     out  1      advance key expansion to the next round key
//  round_en    out  1      datapath state register update enable
//  init_round  out  1      datapath selects initial AddRoundKey only
//  last_round  out  1      datapath bypasses MixColumns
//  round_cnt   out  CNT_W  current round index, 0..NR
//  busy        out  1      block in flight (INIT/ROUND/FINAL)
//  done        out  1      one-cycle pulse on output handshake
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, round_cnt=0; all outputs 0 except ld_ready=1.
//  - States: IDLE, INIT, ROUND, FINAL, HOLD (encoding in package).
//  - ld_ready = (IDLE) | (HOLD & out_ready). It is combinational from state and out_ready only.
//  - Load handshake:
//    - accept = ld_valid & ld_ready & ~abort.
//    - ld_en = kexp_ld = accept, combinational.
//    - Next state on accept = INIT.
//  - INIT: round_cnt=0; init_round=1; round_en=1; kexp_en=1. Next state ROUND (or FINAL if NR==1).
//  - ROUND: round_en=1; kexp_en=1; round_cnt increments each cycle from 1 to NR-1.
//    Leaves for FINAL when round_cnt==NR-1.
//  - FINAL: round_cnt=NR; round_en=1; last_round=1; kexp_en=0. Next state HOLD.
//  - HOLD: out_valid=1, registered and stable until out_ready.
//    - out_ready & ~ld_valid: done=1, next state IDLE, round_cnt cleared to 0.
//    - out_ready & ld_valid (back-to-back): done=1, accept fires, next state INIT.
//      No idle bubble is inserted.
//  - Latency: accept at edge E0; out_valid high from edge E0+NR+2. That is 12 cycles for NR=10.
//    Throughput is one block per NR+2 cycles.
//  - busy = state in {INIT, ROUND, FINAL}. round_en, kexp_en and init_round are 0 outside these states.
//  - abort (sync, highest priority after reset):
//    - Any state goes to IDLE at the next edge; round_cnt returns to 0.
//    - out_valid drops next cycle; done never pulses for an aborted block.
//    - abort suppresses accept in the same cycle.
//  - ld_valid while busy is ignored: ld_ready=0, no capture.
//  - out_ready outside HOLD is ignored.
//  - round_cnt never exceeds NR. Wrap is only via return to 0 on leaving HOLD, or on abort.
//  - Assertions: round_cnt <= NR; $onehot0({init_round, last_round}); out_valid -> state==HOLD.
// STRUCTURE
//  - Package aes_ctrl_pkg: state enum ctrl_state_e; localparam NR_AES128=10, NR_AES192=12, NR_AES256=14.
//  - Single flat module: one state register, one round counter, output decode.
//    No sub-module; the counter is too small to justify one.
//  - All outputs except ld_ready, ld_en, kexp_ld and done are decoded from registered state/counter.
// TESTING
//  1. Reset then single block, NR=10, out_ready=1:
//     ld_en pulse at E0; round_cnt 0,1..9,10; last_round only at cnt 10;
//     out_valid at E0+12; done 1 cycle.
//  2. Backpressure: out_ready=0 for 5 cycles in HOLD ->
//     out_valid held 6 cycles, ld_ready=0 throughout, done only on release.
//  3. Back-to-back: ld_valid held high, out_ready=1 ->
//     second ld_en coincides with first done; blocks 12 cycles apart.
//  4. Abort at round_cnt=5 -> IDLE next edge, round_cnt=0, ld_ready=1, no out_valid, no done.
//     Also abort in HOLD -> out_valid drops, no done.
//  5. Async reset asserted mid-ROUND (between edges) ->
//     outputs clear immediately; ld_ready=1 after release; next block completes normally.
//  6. NR=14 build -> out_valid at E0+16; ld_valid while busy never produces ld_en.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared state encoding and round-count constants for the AES round sequencer.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } ctrl_state_e;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES cipher datapath: load handshake, round stepping,
// key-expansion strobes and a held output handshake. Control only, no data.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR    = 10,
  parameter int CNT_W = $clog2(NR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             out_ready,
  output logic             out_valid,
  input  logic             abort,
  output logic             ld_en,
  output logic             kexp_ld,
  output logic             kexp_en,
  output logic             round_en,
  output logic             init_round,
  output logic             last_round,
  output logic [CNT_W-1:0] round_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR - 1);
  localparam logic [CNT_W-1:0] CNT_NR   = CNT_W'(NR);

  ctrl_state_e state;
  logic        accept;

  // A finished block in HOLD can be retired and the next one accepted in the same cycle.
  assign ld_ready   = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
  assign accept     = ld_valid & ld_ready & ~abort;
  assign ld_en      = accept;
  assign kexp_ld    = accept;
  assign done       = (state == ST_HOLD) & out_ready & ~abort;

  assign busy       = (state == ST_INIT) | (state == ST_ROUND) | (state == ST_FINAL);
  assign round_en   = busy;
  assign kexp_en    = (state == ST_INIT) | (state == ST_ROUND);
  assign init_round = (state == ST_INIT);
  assign last_round = (state == ST_FINAL);
  assign out_valid  = (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          round_cnt <= '0;
          if (accept) state <= ST_INIT;
        end
        ST_INIT: begin
          if (NR == 1) begin
            state     <= ST_FINAL;
            round_cnt <= CNT_NR;
          end else begin
            state     <= ST_ROUND;
            round_cnt <= CNT_W'(1);
          end
        end
        ST_ROUND: begin
          if (round_cnt == CNT_LAST) begin
            state     <= ST_FINAL;
            round_cnt <= CNT_NR;
          end else begin
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        ST_FINAL: state <= ST_HOLD;
        ST_HOLD: begin
          if (out_ready) begin
            state     <= accept ? ST_INIT : ST_IDLE;
            round_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          round_cnt <= '0;
        end
      endcase
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst) round_cnt <= CNT_NR);
  a_round_sel: assert property (@(posedge clk) disable iff (!rst) $onehot0({init_round, last_round}));
  a_out_hold:  assert property (@(posedge clk) disable iff (!rst) out_valid |-> (state == ST_HOLD));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 and NR=14 instances with hand-computed expectations.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       ld_valid = 0, out_ready = 0, abort = 0;
  logic       ld_ready, out_valid, ld_en, kexp_ld, kexp_en, round_en;
  logic       init_round, last_round, busy, done;
  logic [3:0] round_cnt;

  logic       ld_valid14 = 0, out_ready14 = 0, abort14 = 0;
  logic       ld_ready14, out_valid14, ld_en14, kexp_ld14, kexp_en14, round_en14;
  logic       init_round14, last_round14, busy14, done14;
  logic [3:0] round_cnt14;

  int n_checks = 0;
  int n_errors = 0;
  int busy_ld_hits = 0;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .out_ready(out_ready), .out_valid(out_valid), .abort(abort), .ld_en(ld_en),
    .kexp_ld(kexp_ld), .kexp_en(kexp_en), .round_en(round_en), .init_round(init_round),
    .last_round(last_round), .round_cnt(round_cnt), .busy(busy), .done(done)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid14), .ld_ready(ld_ready14),
    .out_ready(out_ready14), .out_valid(out_valid14), .abort(abort14), .ld_en(ld_en14),
    .kexp_ld(kexp_ld14), .kexp_en(kexp_en14), .round_en(round_en14), .init_round(init_round14),
    .last_round(last_round14), .round_cnt(round_cnt14), .busy(busy14), .done(done14)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts edges until the chosen instance shows out_valid, bounded.
  task automatic wait_hold(input bit use14, input int bound, output int lat);
    lat = 0;
    while (((use14 ? out_valid14 : out_valid) == 1'b0) && lat < bound) begin
      step();
      #1;
      lat++;
      if (use14 ? (busy14 & ld_en14) : (busy & ld_en)) busy_ld_hits++;
    end
  endtask

  initial begin
    int lat;
    int hits;

    // Reset state
    #2;
    chk("rst_ld_ready", int'(ld_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(round_cnt), 0);
    chk("rst_round_en", int'(round_en), 0);
    chk("rst_ld_ready14", int'(ld_ready14), 1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1. Single block, out_ready=1
    ld_valid = 1; out_ready = 1;
    #1;
    chk("t1_ld_en", int'(ld_en), 1);
    chk("t1_kexp_ld", int'(kexp_ld), 1);
    step();
    ld_valid = 0;
    #1;
    chk("t1_init_round", int'(init_round), 1);
    chk("t1_init_cnt", int'(round_cnt), 0);
    chk("t1_init_kexp", int'(kexp_en), 1);
    chk("t1_init_ready", int'(ld_ready), 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      #1;
      chk($sformatf("t1_cnt%0d", i), int'(round_cnt), i);
      chk($sformatf("t1_last%0d", i), int'(last_round), 0);
      chk($sformatf("t1_kexp%0d", i), int'(kexp_en), 1);
    end
    step();
    #1;
    chk("t1_final_cnt", int'(round_cnt), 10);
    chk("t1_final_last", int'(last_round), 1);
    chk("t1_final_kexp", int'(kexp_en), 0);
    chk("t1_final_ren", int'(round_en), 1);
    chk("t1_final_ov", int'(out_valid), 0);
    step();
    #1;
    chk("t1_hold_ov", int'(out_valid), 1);
    chk("t1_hold_done", int'(done), 1);
    chk("t1_hold_busy", int'(busy), 0);
    step();
    #1;
    chk("t1_idle_ov", int'(out_valid), 0);
    chk("t1_idle_done", int'(done), 0);
    chk("t1_idle_cnt", int'(round_cnt), 0);

    // 1b. latency measured from the ld_en cycle
    ld_valid = 1; out_ready = 1;
    #1;
    chk("t1b_ld_en", int'(ld_en), 1);
    wait_hold(1'b0, 40, lat);
    ld_valid = 0;
    chk("t1b_latency", lat, 12);

    // 2. Backpressure in HOLD
    step();
    ld_valid = 1; out_ready = 0;
    #1;
    chk("t2_ld_en", int'(ld_en), 1);
    step();
    ld_valid = 0;
    wait_hold(1'b0, 40, lat);
    chk("t2_latency", lat + 1, 12);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || ld_ready !== 1'b0 || done !== 1'b0) hits++;
      step();
      #1;
    end
    chk("t2_held_stall", hits, 0);
    out_ready = 1;
    #1;
    chk("t2_release_ov", int'(out_valid), 1);
    chk("t2_release_done", int'(done), 1);
    chk("t2_release_ready", int'(ld_ready), 1);
    step();
    #1;
    chk("t2_after_ov", int'(out_valid), 0);

    // 3. Back-to-back blocks
    ld_valid = 1; out_ready = 1;
    #1;
    chk("t3_ld_en0", int'(ld_en), 1);
    wait_hold(1'b0, 40, lat);
    chk("t3_lat0", lat, 12);
    chk("t3_done_a", int'(done), 1);
    chk("t3_ld_en_a", int'(ld_en), 1);
    step();
    #1;
    chk("t3_reinit", int'(init_round), 1);
    wait_hold(1'b0, 40, lat);
    chk("t3_spacing", lat + 1, 12);
    ld_valid = 0;
    #1;
    chk("t3_done_b", int'(done), 1);
    chk("t3_ld_en_b", int'(ld_en), 0);
    step();
    #1;
    chk("t3_idle", int'(busy | out_valid), 0);

    // 4. Abort mid-round
    ld_valid = 1;
    step();
    ld_valid = 0;
    lat = 0;
    while (round_cnt != 4'd5 && lat < 30) begin
      step();
      lat++;
    end
    chk("t4_reach5", int'(round_cnt), 5);
    abort = 1;
    #1;
    chk("t4_abort_done", int'(done), 0);
    step();
    abort = 0;
    #1;
    chk("t4_cnt", int'(round_cnt), 0);
    chk("t4_ready", int'(ld_ready), 1);
    chk("t4_busy", int'(busy), 0);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid | done) hits++;
      step();
      #1;
    end
    chk("t4_no_output", hits, 0);

    // 4b. Abort in HOLD
    ld_valid = 1; out_ready = 0;
    step();
    ld_valid = 0;
    wait_hold(1'b0, 40, lat);
    chk("t4b_in_hold", int'(out_valid), 1);
    abort = 1; out_ready = 1;
    #1;
    chk("t4b_done", int'(done), 0);
    step();
    abort = 0;
    #1;
    chk("t4b_ov_drop", int'(out_valid), 0);
    chk("t4b_done_after", int'(done), 0);

    // 4c. Abort suppresses accept in IDLE
    ld_valid = 1; abort = 1;
    #1;
    chk("t4c_ld_en", int'(ld_en), 0);
    step();
    #1;
    chk("t4c_busy", int'(busy), 0);
    ld_valid = 0; abort = 0;

    // 5. Async reset mid-ROUND
    ld_valid = 1;
    step();
    ld_valid = 0;
    step(); step(); step();
    #1;
    chk("t5_cnt3", int'(round_cnt), 3);
    #1;
    rst = 0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_cnt", int'(round_cnt), 0);
    chk("t5_rst_ren", int'(round_en), 0);
    chk("t5_rst_ready", int'(ld_ready), 1);
    @(negedge clk);
    rst = 1;
    step();
    ld_valid = 1;
    #1;
    chk("t5_ld_en", int'(ld_en), 1);
    wait_hold(1'b0, 40, lat);
    ld_valid = 0;
    #1;
    chk("t5_latency", lat, 12);
    chk("t5_done", int'(done), 1);
    step();

    // 6. NR=14 instance, ld_valid held while busy
    ld_valid14 = 1; out_ready14 = 1;
    #1;
    chk("t6_ld_en", int'(ld_en14), 1);
    busy_ld_hits = 0;
    wait_hold(1'b1, 60, lat);
    chk("t6_latency", lat, 16);
    chk("t6_busy_ld_en", busy_ld_hits, 0);
    chk("t6_cnt_hold", int'(round_cnt14), 14);
    ld_valid14 = 0;
    #1;
    chk("t6_done", int'(done14), 1);
    step();
    #1;
    chk("t6_idle", int'(out_valid14 | busy14), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
